// File: rtl/spgd_dither_sequencer.sv
// SPGD iteration controller: dithers the actuator code, measures J+ and J-, then steps U along the gradient.
// Define SPGD_TIMEOUT_EN to build the ADC wait timeout and sticky ERR flag.
module spgd_dither_sequencer #(
  parameter int                   FLOAT_WIDTH = 32,
  parameter int                   DAC_WIDTH   = 14,
  parameter int                   CNT_WIDTH   = 16,
  parameter int                   ITER_WIDTH  = 32,
  parameter logic [DAC_WIDTH-1:0] U_INIT      = 14'h2000,
  parameter int                   TIMEOUT_CYC = 1000000
) (
  input  logic                   ADC_CLK,
  input  logic                   RST_N,
  input  logic                   START,
  input  logic [CNT_WIDTH-1:0]   SETTLE_CYCLES,
  input  logic [DAC_WIDTH-1:0]   DITHER_AMP,
  input  logic [4:0]             GAIN_SHIFT,
  output logic                   ADC_EN,
  input  logic                   ADC_DONE,
  input  logic [FLOAT_WIDTH-1:0] ADC_VALUE,
  output logic [DAC_WIDTH-1:0]   DAC_CODE_OUT,
  output logic [DAC_WIDTH-1:0]   U_CODE,
  output logic [FLOAT_WIDTH:0]   J_DIFF,
  output logic [ITER_WIDTH-1:0]  ITER_COUNT,
  output logic                   BUSY,
  output logic                   ERR
);

  localparam int SUM_W = FLOAT_WIDTH + 3;
  localparam logic signed [SUM_W-1:0] CODE_MAX = {{(SUM_W-DAC_WIDTH){1'b0}}, {DAC_WIDTH{1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE, S_SET_P, S_SETTLE_P, S_MEAS_P, S_SET_M, S_SETTLE_M, S_MEAS_M, S_UPDATE
  } state_t;

  state_t                   r_state;
  logic [DAC_WIDTH-1:0]     r_u;
  logic [DAC_WIDTH-1:0]     r_dac;
  logic                     r_adc_en;
  logic [FLOAT_WIDTH:0]     r_jdiff;
  logic [ITER_WIDTH-1:0]    r_iter;
  logic                     r_busy;
  logic [15:0]              r_lfsr;
  logic [CNT_WIDTH-1:0]     r_settle_cnt;
  logic [CNT_WIDTH-1:0]     r_settle_lat;
  logic [DAC_WIDTH-1:0]     r_amp;
  logic [4:0]               r_shift;
  logic [FLOAT_WIDTH-1:0]   r_jp;
  logic [FLOAT_WIDTH-1:0]   r_jm;
`ifdef SPGD_TIMEOUT_EN
  logic                     r_err;
  logic [31:0]              r_to_cnt;
`endif

  function automatic logic [DAC_WIDTH-1:0] sat_code(input logic signed [SUM_W-1:0] v);
    logic [DAC_WIDTH-1:0] res;
    if (v[SUM_W-1])        res = '0;
    else if (v > CODE_MAX) res = '1;
    else                   res = v[DAC_WIDTH-1:0];
    return res;
  endfunction

  logic                          w_sign;
  logic signed [SUM_W-1:0]       w_u_ext, w_amp_in_ext, w_amp_lat_ext, w_step_ext;
  logic [DAC_WIDTH-1:0]          w_dac_p, w_dac_m, w_u_new;
  logic signed [FLOAT_WIDTH:0]   w_dj;
  logic signed [FLOAT_WIDTH+1:0] w_dj_ext, w_sdj, w_step;
  logic [15:0]                   w_lfsr_next;

  // Dither sign comes from the LFSR; SET_P uses the live amplitude, SET_M the one latched at SET_P
  assign w_sign        = r_lfsr[0];
  assign w_u_ext       = $signed({{(SUM_W-DAC_WIDTH){1'b0}}, r_u});
  assign w_amp_in_ext  = $signed({{(SUM_W-DAC_WIDTH){1'b0}}, DITHER_AMP});
  assign w_amp_lat_ext = $signed({{(SUM_W-DAC_WIDTH){1'b0}}, r_amp});
  assign w_dac_p       = sat_code(w_sign ? w_u_ext + w_amp_in_ext  : w_u_ext - w_amp_in_ext);
  assign w_dac_m       = sat_code(w_sign ? w_u_ext - w_amp_lat_ext : w_u_ext + w_amp_lat_ext);

  assign w_dj          = $signed({r_jp[FLOAT_WIDTH-1], r_jp}) - $signed({r_jm[FLOAT_WIDTH-1], r_jm});
  assign w_dj_ext      = {w_dj[FLOAT_WIDTH], w_dj};
  assign w_sdj         = w_sign ? w_dj_ext : -w_dj_ext;
  assign w_step        = w_sdj >>> r_shift;
  assign w_step_ext    = {w_step[FLOAT_WIDTH+1], w_step};
  assign w_u_new       = sat_code(w_u_ext + w_step_ext);
  assign w_lfsr_next   = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};

  always_ff @(posedge ADC_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= S_IDLE;
      r_u          <= U_INIT;
      r_dac        <= U_INIT;
      r_adc_en     <= 1'b0;
      r_jdiff      <= '0;
      r_iter       <= '0;
      r_busy       <= 1'b0;
      r_lfsr       <= 16'hACE1;
      r_settle_cnt <= '0;
`ifdef SPGD_TIMEOUT_EN
      r_err        <= 1'b0;
      r_to_cnt     <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_state <= S_SET_P;
            r_busy  <= 1'b1;
`ifdef SPGD_TIMEOUT_EN
            r_err   <= 1'b0;
`endif
          end
        end
        S_SET_P: begin
          r_dac        <= w_dac_p;
          r_settle_cnt <= SETTLE_CYCLES;
          r_state      <= S_SETTLE_P;
        end
        S_SETTLE_P, S_SETTLE_M: begin
          if (r_settle_cnt <= CNT_WIDTH'(1)) begin
            r_adc_en <= 1'b1;
            r_state  <= (r_state == S_SETTLE_P) ? S_MEAS_P : S_MEAS_M;
`ifdef SPGD_TIMEOUT_EN
            r_to_cnt <= '0;
`endif
          end else begin
            r_settle_cnt <= r_settle_cnt - CNT_WIDTH'(1);
          end
        end
        S_MEAS_P, S_MEAS_M: begin
          if (ADC_DONE) begin
            r_adc_en <= 1'b0;
            r_state  <= (r_state == S_MEAS_P) ? S_SET_M : S_UPDATE;
          end
`ifdef SPGD_TIMEOUT_EN
          // Give up on a silent ADC: park the DAC back on U and leave U untouched
          else if (r_to_cnt == 32'(TIMEOUT_CYC - 1)) begin
            r_adc_en <= 1'b0;
            r_err    <= 1'b1;
            r_dac    <= r_u;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 32'd1;
          end
`endif
        end
        S_SET_M: begin
          r_dac        <= w_dac_m;
          r_settle_cnt <= r_settle_lat;
          r_state      <= S_SETTLE_M;
        end
        S_UPDATE: begin
          r_jdiff <= w_dj;
          r_u     <= w_u_new;
          r_dac   <= w_u_new;
          r_iter  <= r_iter + ITER_WIDTH'(1);
          r_lfsr  <= w_lfsr_next;
          r_busy  <= START;
          r_state <= START ? S_SET_P : S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Per-iteration configuration and measurements carry no reset; each iteration rewrites them before use
  always_ff @(posedge ADC_CLK) begin
    if (r_state == S_SET_P) begin
      r_amp        <= DITHER_AMP;
      r_shift      <= GAIN_SHIFT;
      r_settle_lat <= SETTLE_CYCLES;
    end
    if (r_state == S_MEAS_P && ADC_DONE) r_jp <= ADC_VALUE;
    if (r_state == S_MEAS_M && ADC_DONE) r_jm <= ADC_VALUE;
  end

  assign ADC_EN       = r_adc_en;
  assign DAC_CODE_OUT = r_dac;
  assign U_CODE       = r_u;
  assign J_DIFF       = r_jdiff;
  assign ITER_COUNT   = r_iter;
  assign BUSY         = r_busy;
`ifdef SPGD_TIMEOUT_EN
  assign ERR          = r_err;
`else
  assign ERR          = 1'b0;
`endif

endmodule

// File: tb/tb_spgd_dither_sequencer.sv
// Randomized bench for spgd_dither_sequencer against an arithmetic model of the SPGD iteration.
module tb_spgd_dither_sequencer;

  logic        ADC_CLK = 1'b0;
  logic        RST_N, START, ADC_DONE, ADC_EN, BUSY, ERR;
  logic [15:0] SETTLE_CYCLES;
  logic [13:0] DITHER_AMP, DAC_CODE_OUT, U_CODE;
  logic [4:0]  GAIN_SHIFT;
  logic [31:0] ADC_VALUE, ITER_COUNT;
  logic [32:0] J_DIFF;

  int vectors = 0;
  int miscompares = 0;

  int          m_u;
  logic [15:0] m_lfsr;
  int unsigned m_iter;
  logic [32:0] m_jd;

  int i_max = 32'h7FFF_FFFF;
  int i_min = 32'h8000_0000;

  always #5 ADC_CLK = ~ADC_CLK;

  spgd_dither_sequencer #(.TIMEOUT_CYC(50)) dut (
    .ADC_CLK(ADC_CLK), .RST_N(RST_N), .START(START), .SETTLE_CYCLES(SETTLE_CYCLES),
    .DITHER_AMP(DITHER_AMP), .GAIN_SHIFT(GAIN_SHIFT), .ADC_EN(ADC_EN), .ADC_DONE(ADC_DONE),
    .ADC_VALUE(ADC_VALUE), .DAC_CODE_OUT(DAC_CODE_OUT), .U_CODE(U_CODE), .J_DIFF(J_DIFF),
    .ITER_COUNT(ITER_COUNT), .BUSY(BUSY), .ERR(ERR)
  );

  task automatic tick();
    @(posedge ADC_CLK);
    #1;
  endtask

  function automatic int clampc(input longint v);
    if (v < 0) return 0;
    if (v > 16383) return 16383;
    return int'(v);
  endfunction

  function automatic int sgn();
    return m_lfsr[0] ? 1 : -1;
  endfunction

  task automatic model_reset();
    m_u = 8192; m_lfsr = 16'hACE1; m_iter = 0; m_jd = '0;
  endtask

  // Gradient step: dJ = Jp - Jm, U += floor(s*dJ / 2^shift), clamped to the DAC range
  task automatic model_update(input int jp, input int jm, input int shift);
    longint dj, step;
    dj     = longint'(jp) - longint'(jm);
    step   = (longint'(sgn()) * dj) >>> shift;
    m_u    = clampc(longint'(m_u) + step);
    m_jd   = dj[32:0];
    m_iter = m_iter + 1;
    m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
  endtask

  // Waits for the ADC enable while throwing spurious ADC_DONE pulses that must be ignored
  task automatic wait_adc_en(output bit ok);
    int n;
    n = 0; ok = 1'b0;
    while (!ok && n < 300) begin
      if (ADC_EN === 1'b1) ok = 1'b1;
      else begin
        ADC_DONE  = 1'($urandom_range(0, 1));
        ADC_VALUE = $urandom();
        tick();
        n++;
      end
    end
    ADC_DONE = 1'b0;
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL wait_adc_en: ADC_EN=%b after 300 cycles, required 1", ADC_EN);
    end
  endtask

  task automatic run_iter(input int a, input int settle, input int shift, input int jp,
                          input int jm, input int dly, input bit drop);
    int s, ep, em;
    bit ok;
    s  = sgn();
    ep = clampc(longint'(m_u) + s * a);
    em = clampc(longint'(m_u) - s * a);
    DITHER_AMP = 14'(a); SETTLE_CYCLES = 16'(settle); GAIN_SHIFT = 5'(shift); START = 1'b1;
    wait_adc_en(ok);
    if (!ok) return;
    vectors++;
    if (DAC_CODE_OUT !== 14'(ep)) begin
      miscompares++; $display("FAIL dac_plus: got %0d, required %0d", DAC_CODE_OUT, ep);
    end
    DITHER_AMP = 14'($urandom()); GAIN_SHIFT = 5'($urandom()); SETTLE_CYCLES = 16'($urandom_range(0, 3));
    repeat (dly) begin ADC_VALUE = $urandom(); tick(); end
    vectors++;
    if (ADC_EN !== 1'b1) begin
      miscompares++; $display("FAIL adc_en_hold: got %b, required 1", ADC_EN);
    end
    ADC_VALUE = jp; ADC_DONE = 1'b1; tick(); ADC_DONE = 1'b0;
    vectors++;
    if (ADC_EN !== 1'b0) begin
      miscompares++; $display("FAIL adc_en_release: got %b, required 0", ADC_EN);
    end
    wait_adc_en(ok);
    if (!ok) return;
    vectors++;
    if (DAC_CODE_OUT !== 14'(em)) begin
      miscompares++; $display("FAIL dac_minus: got %0d, required %0d", DAC_CODE_OUT, em);
    end
    if (drop) START = 1'b0;
    repeat (dly) begin ADC_VALUE = $urandom(); tick(); end
    ADC_VALUE = jm; ADC_DONE = 1'b1; tick(); ADC_DONE = 1'b0;
    tick();
    model_update(jp, jm, shift);
    vectors++;
    if (U_CODE !== 14'(m_u) || DAC_CODE_OUT !== 14'(m_u)) begin
      miscompares++; $display("FAIL update_u: U=%0d DAC=%0d, required %0d", U_CODE, DAC_CODE_OUT, m_u);
    end
    vectors++;
    if (J_DIFF !== m_jd) begin
      miscompares++; $display("FAIL j_diff: got %h, required %h", J_DIFF, m_jd);
    end
    vectors++;
    if (ITER_COUNT !== m_iter) begin
      miscompares++; $display("FAIL iter_count: got %0d, required %0d", ITER_COUNT, m_iter);
    end
    vectors++;
    if (BUSY !== !drop) begin
      miscompares++; $display("FAIL busy_after_update: got %b, required %b", BUSY, !drop);
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0; START = 1'b1;
    repeat (4) tick();
    vectors++;
    if (DAC_CODE_OUT !== 14'h2000 || U_CODE !== 14'h2000) begin
      miscompares++; $display("FAIL reset_codes: DAC=%h U=%h, required 2000", DAC_CODE_OUT, U_CODE);
    end
    vectors++;
    if (ADC_EN !== 1'b0 || BUSY !== 1'b0 || ERR !== 1'b0) begin
      miscompares++; $display("FAIL reset_ctrl: en=%b busy=%b err=%b, required 0 0 0", ADC_EN, BUSY, ERR);
    end
    vectors++;
    if (ITER_COUNT !== 32'd0 || J_DIFF !== 33'd0) begin
      miscompares++; $display("FAIL reset_counts: iter=%0d jd=%h, required 0 0", ITER_COUNT, J_DIFF);
    end
    START = 1'b0; RST_N = 1'b1;
    repeat (3) tick();
    vectors++;
    if (BUSY !== 1'b0 || DAC_CODE_OUT !== 14'h2000) begin
      miscompares++; $display("FAIL idle_hold: busy=%b DAC=%h, required 0 2000", BUSY, DAC_CODE_OUT);
    end
    model_reset();
  endtask

  task automatic test_nominal();
    run_iter(100, 2, 8, 32'h0001_0000, 32'h0000_8000, 0, 0);
    vectors++;
    if (U_CODE !== 14'd8320) begin
      miscompares++; $display("FAIL nominal_u: got %0d, required 8320", U_CODE);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++)
      run_iter($urandom_range(0, 3000), $urandom_range(0, 4), $urandom_range(0, 31),
               int'($urandom()), int'($urandom()), $urandom_range(0, 3), i == 7);
  endtask

  task automatic drive_u_to(input int target);
    int s;
    s = sgn();
    run_iter(0, 1, 0, s * (target - m_u), 0, 0, 0);
  endtask

  task automatic test_clamp();
    int s;
    drive_u_to(16380);
    vectors++;
    if (U_CODE !== 14'd16380) begin
      miscompares++; $display("FAIL clamp_prep_hi: got %0d, required 16380", U_CODE);
    end
    s = sgn();
    run_iter(100, 1, 0, s > 0 ? i_max : i_min, s > 0 ? i_min : i_max, 1, 0);
    vectors++;
    if (U_CODE !== 14'd16383) begin
      miscompares++; $display("FAIL clamp_hi: got %0d, required 16383", U_CODE);
    end
    drive_u_to(5);
    vectors++;
    if (U_CODE !== 14'd5) begin
      miscompares++; $display("FAIL clamp_prep_lo: got %0d, required 5", U_CODE);
    end
    s = sgn();
    run_iter(100, 0, 0, s > 0 ? i_min : i_max, s > 0 ? i_max : i_min, 0, 0);
    vectors++;
    if (U_CODE !== 14'd0) begin
      miscompares++; $display("FAIL clamp_lo: got %0d, required 0", U_CODE);
    end
    // Smallest negative step at the widest shift rounds to -1
    drive_u_to(3000);
    s = sgn();
    run_iter(40, 2, 31, s > 0 ? -3 : 3, 0, 2, 1);
  endtask

  task automatic test_min_latency();
    int s, ep, em, jp, jm;
    s  = sgn();
    ep = clampc(longint'(m_u) + s * 200);
    em = clampc(longint'(m_u) - s * 200);
    jp = int'($urandom()); jm = int'($urandom());
    DITHER_AMP = 14'd200; SETTLE_CYCLES = 16'd0; GAIN_SHIFT = 5'd4;
    ADC_VALUE = jp; ADC_DONE = 1'b1; START = 1'b1;
    tick();
    vectors++;
    if (BUSY !== 1'b1 || DAC_CODE_OUT !== 14'(m_u)) begin
      miscompares++; $display("FAIL lat_cycle1: busy=%b DAC=%0d, required 1 %0d", BUSY, DAC_CODE_OUT, m_u);
    end
    tick();
    vectors++;
    if (DAC_CODE_OUT !== 14'(ep)) begin
      miscompares++; $display("FAIL lat_dac_plus: got %0d, required %0d", DAC_CODE_OUT, ep);
    end
    tick(); tick();
    ADC_VALUE = jm;
    tick();
    vectors++;
    if (DAC_CODE_OUT !== 14'(em)) begin
      miscompares++; $display("FAIL lat_dac_minus: got %0d, required %0d", DAC_CODE_OUT, em);
    end
    tick();
    START = 1'b0;
    tick();
    vectors++;
    if (ITER_COUNT !== m_iter) begin
      miscompares++; $display("FAIL lat_early: iter=%0d, required %0d", ITER_COUNT, m_iter);
    end
    tick();
    ADC_DONE = 1'b0;
    model_update(jp, jm, 4);
    vectors++;
    if (ITER_COUNT !== m_iter || BUSY !== 1'b0) begin
      miscompares++; $display("FAIL lat_done: iter=%0d busy=%b, required %0d 0", ITER_COUNT, BUSY, m_iter);
    end
    vectors++;
    if (U_CODE !== 14'(m_u) || J_DIFF !== m_jd) begin
      miscompares++; $display("FAIL lat_update: U=%0d jd=%h, required %0d %h", U_CODE, J_DIFF, m_u, m_jd);
    end
    tick();
    vectors++;
    if (ADC_EN !== 1'b0 || DAC_CODE_OUT !== 14'(m_u)) begin
      miscompares++; $display("FAIL lat_idle: en=%b DAC=%0d, required 0 %0d", ADC_EN, DAC_CODE_OUT, m_u);
    end
  endtask

  task automatic test_hang();
    bit ok;
`ifndef SPGD_TIMEOUT_EN
    int jp, jm;
`endif
    DITHER_AMP = 14'd10; SETTLE_CYCLES = 16'd1; GAIN_SHIFT = 5'd2; START = 1'b1;
    wait_adc_en(ok);
    START = 1'b0; ADC_DONE = 1'b0;
`ifdef SPGD_TIMEOUT_EN
    repeat (49) tick();
    vectors++;
    if (ERR !== 1'b0 || ADC_EN !== 1'b1) begin
      miscompares++; $display("FAIL timeout_early: err=%b en=%b, required 0 1", ERR, ADC_EN);
    end
    tick();
    vectors++;
    if (ERR !== 1'b1 || ADC_EN !== 1'b0 || BUSY !== 1'b0) begin
      miscompares++; $display("FAIL timeout_flag: err=%b en=%b busy=%b, required 1 0 0", ERR, ADC_EN, BUSY);
    end
    vectors++;
    if (DAC_CODE_OUT !== 14'(m_u) || U_CODE !== 14'(m_u) || ITER_COUNT !== m_iter) begin
      miscompares++; $display("FAIL timeout_park: DAC=%0d U=%0d iter=%0d, required %0d %0d %0d",
                              DAC_CODE_OUT, U_CODE, ITER_COUNT, m_u, m_u, m_iter);
    end
    START = 1'b1;
    tick();
    vectors++;
    if (ERR !== 1'b0) begin
      miscompares++; $display("FAIL err_clear: got %b, required 0", ERR);
    end
    run_iter(60, 1, 1, int'($urandom()), int'($urandom()), 1, 1);
`else
    repeat (60) tick();
    vectors++;
    if (ERR !== 1'b0 || ADC_EN !== 1'b1 || BUSY !== 1'b1) begin
      miscompares++; $display("FAIL hang_wait: err=%b en=%b busy=%b, required 0 1 1", ERR, ADC_EN, BUSY);
    end
    jp = int'($urandom()); jm = int'($urandom());
    ADC_VALUE = jp; ADC_DONE = 1'b1; tick(); ADC_DONE = 1'b0;
    wait_adc_en(ok);
    ADC_VALUE = jm; ADC_DONE = 1'b1; tick(); ADC_DONE = 1'b0;
    tick();
    model_update(jp, jm, 2);
    vectors++;
    if (U_CODE !== 14'(m_u) || J_DIFF !== m_jd || BUSY !== 1'b0) begin
      miscompares++; $display("FAIL hang_resume: U=%0d jd=%h busy=%b, required %0d %h 0",
                              U_CODE, J_DIFF, BUSY, m_u, m_jd);
    end
`endif
  endtask

  task automatic test_async_reset();
    bit ok;
    DITHER_AMP = 14'd50; SETTLE_CYCLES = 16'd5; GAIN_SHIFT = 5'd0; START = 1'b1;
    wait_adc_en(ok);
    ADC_VALUE = $urandom(); ADC_DONE = 1'b1; tick(); ADC_DONE = 1'b0;
    tick(); tick();
    vectors++;
    if (BUSY !== 1'b1 || ADC_EN !== 1'b0) begin
      miscompares++; $display("FAIL pre_reset: busy=%b en=%b, required 1 0", BUSY, ADC_EN);
    end
    #2 RST_N = 1'b0;
    #1;
    vectors++;
    if (DAC_CODE_OUT !== 14'h2000 || U_CODE !== 14'h2000 || ADC_EN !== 1'b0 || BUSY !== 1'b0) begin
      miscompares++; $display("FAIL async_reset: DAC=%h U=%h en=%b busy=%b, required 2000 2000 0 0",
                              DAC_CODE_OUT, U_CODE, ADC_EN, BUSY);
    end
    vectors++;
    if (ITER_COUNT !== 32'd0 || J_DIFF !== 33'd0 || ERR !== 1'b0) begin
      miscompares++; $display("FAIL async_reset_cnt: iter=%0d jd=%h err=%b, required 0 0 0",
                              ITER_COUNT, J_DIFF, ERR);
    end
    START = 1'b0;
    model_reset();
    tick();
    RST_N = 1'b1;
    tick();
    run_iter(300, 2, 3, int'($urandom()), int'($urandom()), 1, 1);
  endtask

  initial begin
    RST_N = 1'b0; START = 1'b0; ADC_DONE = 1'b0; ADC_VALUE = '0;
    SETTLE_CYCLES = '0; DITHER_AMP = '0; GAIN_SHIFT = '0;
    model_reset();
    test_reset();
    test_nominal();
    test_back_to_back();
    test_clamp();
    test_min_latency();
    test_hang();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
